// File: rtl/axis_sa_pkg.sv
// Shared widths and the fixed-point helpers used by the requantisation lanes.
// The helpers work at a wide signed width so callers only need to cast.
package axis_sa_pkg;

   localparam int WY_DEF = 16;
   localparam int WO_DEF = 8;
   localparam int CALC_W = 64;

   typedef logic signed [CALC_W-1:0] calc_t;

   // Round-half-up arithmetic right shift; a shift of zero passes the value through.
   function automatic calc_t round_shift(input calc_t value, input int unsigned shift);
      if (shift == 0)
         return value;
      return (value + (calc_t'(1) <<< (shift - 1))) >>> shift;
   endfunction

   function automatic calc_t sat_signed(input calc_t value, input int unsigned wo);
      calc_t hi;
      calc_t lo;
      hi = (calc_t'(1) <<< (wo - 1)) - calc_t'(1);
      lo = -(calc_t'(1) <<< (wo - 1));
      if (value > hi)
         return hi;
      if (value < lo)
         return lo;
      return value;
   endfunction

endpackage

// File: rtl/requant_lane.sv
// One lane of the requantiser: bias add, rounding shift, saturate/ReLU.
// All three data registers advance together on en.
module requant_lane
   import axis_sa_pkg::*;
#(
   parameter int WY = WY_DEF,
   parameter int WB = 16,
   parameter int WO = WO_DEF,
   parameter int WS = $clog2(WY)
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic          en,
   input  logic [WY-1:0] data,
   input  logic [WB-1:0] bias,
   input  logic [WS-1:0] shift,
   input  logic          relu,
   output logic [WO-1:0] q
);

   logic signed [WY:0]   sum;
   logic signed [WY+1:0] t;
   calc_t                sat;

   always_comb begin
      sat = sat_signed(calc_t'(t), WO);
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         sum <= '0;
         t   <= '0;
         q   <= '0;
      end else if (en) begin
         sum <= (WY+1)'($signed(data)) + (WY+1)'($signed(bias));
         t   <= (WY+2)'(round_shift(calc_t'(sum), 32'(shift)));
         q   <= (relu && sat < 0) ? '0 : sat[WO-1:0];
      end
   end

endmodule

// File: rtl/axis_sa_requant.sv
// Systolic-array output stage: per-column bias, rounding shift, saturation and
// optional ReLU over a 3-stage stall-all pipeline with between-packet config.
module axis_sa_requant
   import axis_sa_pkg::*;
#(
   parameter int R  = 4,
   parameter int C  = 8,
   parameter int WY = WY_DEF,
   parameter int WB = 16,
   parameter int WO = WO_DEF,
   parameter int WS = $clog2(WY)
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic                 s_valid,
   output logic                 s_ready,
   input  logic                 s_last,
   input  logic [R-1:0][WY-1:0] s_data,
   input  logic                 cfg_valid,
   output logic                 cfg_ready,
   input  logic [C-1:0][WB-1:0] cfg_bias,
   input  logic [WS-1:0]        cfg_shift,
   input  logic                 cfg_relu,
   output logic                 m_valid,
   input  logic                 m_ready,
   output logic                 m_last,
   output logic [R-1:0][WO-1:0] m_data,
   output logic                 err_last
);

   localparam int            CW       = (C > 1) ? $clog2(C) : 1;
   localparam logic [CW-1:0] COL_LAST = CW'(C - 1);

   logic [CW-1:0]        col;
   logic [C-1:0][WB-1:0] bias_q;
   logic [WS-1:0]        shift_q;
   logic                 relu_q;
   logic                 v1, v2, v3;
   logic                 l1, l2, l3;
   logic                 err_q;
   logic                 en, cfg_fire, acc;

   assign en        = !v3 || m_ready;
   assign cfg_ready = (col == '0) && !v1 && !v2 && !v3;
   assign cfg_fire  = cfg_valid && cfg_ready;
   assign s_ready   = en && !cfg_fire;
   assign acc       = s_valid && s_ready;

   assign m_valid  = v3;
   assign m_last   = l3;
   assign err_last = err_q;

   always_ff @(posedge clk) begin
      if (!rstn) begin
         v1      <= 1'b0;
         v2      <= 1'b0;
         v3      <= 1'b0;
         l1      <= 1'b0;
         l2      <= 1'b0;
         l3      <= 1'b0;
         col     <= '0;
         err_q   <= 1'b0;
         bias_q  <= '0;
         shift_q <= '0;
         relu_q  <= 1'b0;
      end else begin
         if (en) begin
            v1 <= acc;
            l1 <= acc && s_last;
            v2 <= v1;
            l2 <= l1;
            v3 <= v2;
            l3 <= l2;
         end
         // An early s_last is flagged and restarts the column count.
         if (acc) begin
            col <= (s_last || col == COL_LAST) ? '0 : col + CW'(1);
            if (s_last && col != COL_LAST)
               err_q <= 1'b1;
         end
         if (cfg_fire) begin
            bias_q  <= cfg_bias;
            shift_q <= cfg_shift;
            relu_q  <= cfg_relu;
         end
      end
   end

   for (genvar r = 0; r < R; r++) begin : g_lane
      requant_lane #(.WY(WY), .WB(WB), .WO(WO), .WS(WS)) u_lane (
         .clk   (clk),
         .rstn  (rstn),
         .en    (en),
         .data  (s_data[r]),
         .bias  (bias_q[col]),
         .shift (shift_q),
         .relu  (relu_q),
         .q     (m_data[r])
      );
   end

endmodule

// File: tb/tb_axis_sa_requant.sv
// Directed self-checking bench for axis_sa_requant with hand-computed results.
module tb_axis_sa_requant;

   localparam int R  = 4;
   localparam int C  = 8;
   localparam int WY = 16;
   localparam int WB = 16;
   localparam int WO = 8;
   localparam int WS = 4;

   logic                 clk;
   logic                 rstn;
   logic                 s_valid, s_ready, s_last;
   logic [R-1:0][WY-1:0] s_data;
   logic                 cfg_valid, cfg_ready;
   logic [C-1:0][WB-1:0] cfg_bias;
   logic [WS-1:0]        cfg_shift;
   logic                 cfg_relu;
   logic                 m_valid, m_ready, m_last;
   logic [R-1:0][WO-1:0] m_data;
   logic                 err_last;

   int n_cmp = 0;
   int n_err = 0;

   axis_sa_requant #(.R(R), .C(C), .WY(WY), .WB(WB), .WO(WO), .WS(WS)) dut (
      .clk       (clk),
      .rstn      (rstn),
      .s_valid   (s_valid),
      .s_ready   (s_ready),
      .s_last    (s_last),
      .s_data    (s_data),
      .cfg_valid (cfg_valid),
      .cfg_ready (cfg_ready),
      .cfg_bias  (cfg_bias),
      .cfg_shift (cfg_shift),
      .cfg_relu  (cfg_relu),
      .m_valid   (m_valid),
      .m_ready   (m_ready),
      .m_last    (m_last),
      .m_data    (m_data),
      .err_last  (err_last)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rstn      = 1'b0;
      s_valid   = 1'b0;
      s_last    = 1'b0;
      cfg_valid = 1'b0;
      m_ready   = 1'b1;
      tick();
      tick();
      rstn = 1'b1;
   endtask

   task automatic do_cfg(input logic [C-1:0][WB-1:0] b, input logic [WS-1:0] sh, input logic rl);
      bit done = 0;
      cfg_bias  = b;
      cfg_shift = sh;
      cfg_relu  = rl;
      cfg_valid = 1'b1;
      for (int n = 0; n < 50 && !done; n++) begin
         #1;
         done = cfg_ready;
         tick();
      end
      cfg_valid = 1'b0;
      n_cmp++;
      if (!done) begin
         n_err++;
         $display("FAIL cfg_load_timeout got=0 exp=1");
      end
   endtask

   // Sends one beat and waits for its result; lat counts edges from acceptance.
   task automatic one_beat(input logic [R-1:0][WY-1:0] d, input logic last,
                           output logic [R-1:0][WO-1:0] q, output logic ql, output int lat);
      bit acc = 0;
      s_valid = 1'b1;
      s_data  = d;
      s_last  = last;
      for (int n = 0; n < 20 && !acc; n++) begin
         #1;
         acc = s_ready;
         tick();
      end
      s_valid = 1'b0;
      s_last  = 1'b0;
      lat = 1;
      while (!m_valid && lat < 20) begin
         tick();
         lat++;
      end
      q  = m_data;
      ql = m_last;
      if (!acc) lat = 99;
   endtask

   function automatic logic [C-1:0][WB-1:0] ramp_bias();
      logic [C-1:0][WB-1:0] b;
      for (int c = 0; c < C; c++) b[c] = 16'(10 * c);
      return b;
   endfunction

   task automatic test_reset();
      s_valid = 1'b1;
      s_data  = {4{16'h1234}};
      do_reset();
      n_cmp += 6;
      if (m_valid !== 1'b0) begin n_err++; $display("FAIL rst_m_valid got=%b exp=0", m_valid); end
      if (m_last !== 1'b0) begin n_err++; $display("FAIL rst_m_last got=%b exp=0", m_last); end
      if (m_data !== '0) begin n_err++; $display("FAIL rst_m_data got=%h exp=0", m_data); end
      if (err_last !== 1'b0) begin n_err++; $display("FAIL rst_err_last got=%b exp=0", err_last); end
      if (cfg_ready !== 1'b1) begin n_err++; $display("FAIL rst_cfg_ready got=%b exp=1", cfg_ready); end
      if (s_ready !== 1'b1) begin n_err++; $display("FAIL rst_s_ready got=%b exp=1", s_ready); end
   endtask

   task automatic test_basic();
      logic [C-1:0][WB-1:0] b = '0;
      logic [R-1:0][WO-1:0] q;
      logic ql;
      int lat;
      do_reset();
      b[0] = 16'd24;
      do_cfg(b, 4'd4, 1'b0);
      one_beat({16'h0000, 16'h0000, 16'h0000, 16'h03E8}, 1'b0, q, ql, lat);
      n_cmp += 3;
      if (lat !== 3) begin n_err++; $display("FAIL basic_latency got=%0d exp=3", lat); end
      if (q !== {8'h02, 8'h02, 8'h02, 8'h40}) begin n_err++; $display("FAIL basic_data got=%h exp=02020240", q); end
      if (ql !== 1'b0) begin n_err++; $display("FAIL basic_last got=%b exp=0", ql); end
   endtask

   task automatic test_sat_relu_round();
      logic [C-1:0][WB-1:0] b = '0;
      logic [R-1:0][WO-1:0] q;
      logic ql;
      int lat;
      do_reset();
      b[0] = 16'h7FFF;
      do_cfg(b, 4'd0, 1'b0);
      one_beat({16'h8000, 16'h0000, 16'h0000, 16'h7FFF}, 1'b0, q, ql, lat);
      n_cmp++;
      if (q !== {8'hFF, 8'h7F, 8'h7F, 8'h7F}) begin n_err++; $display("FAIL sat_pos got=%h exp=ff7f7f7f", q); end
      one_beat({16'h0064, 16'hFFFB, 16'hFED4, 16'h0000}, 1'b0, q, ql, lat);
      n_cmp++;
      if (q !== {8'h64, 8'hFB, 8'h80, 8'h00}) begin n_err++; $display("FAIL sat_neg got=%h exp=64fb8000", q); end
      do_reset();
      do_cfg('0, 4'd1, 1'b0);
      one_beat({16'hFFFF, 16'hFFFB, 16'hFED4, 16'h0003}, 1'b0, q, ql, lat);
      n_cmp++;
      if (q !== {8'h00, 8'hFE, 8'h80, 8'h02}) begin n_err++; $display("FAIL round_shift1 got=%h exp=00fe8002", q); end
      do_reset();
      do_cfg('0, 4'd0, 1'b1);
      one_beat({16'h00C8, 16'hFFFB, 16'hFED4, 16'h0005}, 1'b0, q, ql, lat);
      n_cmp++;
      if (q !== {8'h7F, 8'h00, 8'h00, 8'h05}) begin n_err++; $display("FAIL relu got=%h exp=7f000005", q); end
   endtask

   task automatic test_col_bias();
      logic [R-1:0][WO-1:0] e;
      int oi = 0;
      do_reset();
      do_cfg(ramp_bias(), 4'd0, 1'b0);
      for (int k = 0; k < 12; k++) begin
         s_valid = (k < 8);
         s_data  = {4{16'h0001}};
         s_last  = (k == 7);
         tick();
         if (m_valid) begin
            for (int r = 0; r < R; r++) e[r] = 8'(1 + 10 * oi);
            n_cmp += 2;
            if (m_data !== e) begin n_err++; $display("FAIL col_bias_data[%0d] got=%h exp=%h", oi, m_data, e); end
            if (m_last !== (oi == 7)) begin n_err++; $display("FAIL col_bias_last[%0d] got=%b exp=%b", oi, m_last, oi == 7); end
            oi++;
         end
      end
      s_valid = 1'b0;
      s_last  = 1'b0;
      n_cmp += 2;
      if (oi !== 8) begin n_err++; $display("FAIL col_bias_count got=%0d exp=8", oi); end
      if (err_last !== 1'b0) begin n_err++; $display("FAIL col_bias_err got=%b exp=0", err_last); end
   endtask

   task automatic test_back_to_back();
      logic [R-1:0][WO-1:0] prev_d = '0;
      logic [R-1:0][WO-1:0] e;
      bit prev_stall = 0;
      bit acc, out, extra;
      int pi = 0;
      int oi = 0;
      do_reset();
      do_cfg(ramp_bias(), 4'd0, 1'b0);
      for (int cyc = 0; cyc < 400 && oi < 24; cyc++) begin
         m_ready = (cyc >= 6 && cyc < 12) ? 1'b0 : ($urandom_range(0, 3) != 0);
         s_valid = (pi < 24);
         for (int r = 0; r < R; r++) s_data[r] = 16'((pi / 8) * 8 + (pi % 8) + r);
         s_last = ((pi % 8) == 7);
         #1;
         if (prev_stall) begin
            n_cmp++;
            if (m_data !== prev_d) begin n_err++; $display("FAIL stall_hold got=%h exp=%h", m_data, prev_d); end
         end
         if (m_valid && !m_ready) begin
            n_cmp++;
            if (s_ready !== 1'b0) begin n_err++; $display("FAIL stall_s_ready got=%b exp=0", s_ready); end
         end
         acc = s_valid && s_ready;
         out = m_valid && m_ready;
         if (out) begin
            for (int r = 0; r < R; r++) e[r] = 8'((oi / 8) * 8 + (oi % 8) + r + 10 * (oi % 8));
            n_cmp += 2;
            if (m_data !== e) begin n_err++; $display("FAIL b2b_data[%0d] got=%h exp=%h", oi, m_data, e); end
            if (m_last !== ((oi % 8) == 7)) begin n_err++; $display("FAIL b2b_last[%0d] got=%b exp=%b", oi, m_last, (oi % 8) == 7); end
            oi++;
         end
         prev_stall = m_valid && !m_ready;
         prev_d     = m_data;
         tick();
         if (acc) pi++;
      end
      s_valid = 1'b0;
      s_last  = 1'b0;
      m_ready = 1'b1;
      extra = 0;
      for (int k = 0; k < 5; k++) begin
         if (m_valid) extra = 1;
         tick();
      end
      n_cmp += 3;
      if (oi !== 24) begin n_err++; $display("FAIL b2b_count got=%0d exp=24", oi); end
      if (extra !== 1'b0) begin n_err++; $display("FAIL b2b_duplicate got=1 exp=0"); end
      if (err_last !== 1'b0) begin n_err++; $display("FAIL b2b_err got=%b exp=0", err_last); end
   endtask

   task automatic test_cfg_gating();
      logic [R-1:0][WO-1:0] q;
      logic ql;
      int lat;
      int outs = 0;
      do_reset();
      do_cfg('0, 4'd0, 1'b0);
      cfg_bias  = '0;
      cfg_shift = 4'd2;
      cfg_relu  = 1'b0;
      for (int k = 0; k < 11; k++) begin
         s_valid = (k < 8);
         s_data  = {4{16'h0040}};
         s_last  = (k == 7);
         if (k == 2) cfg_valid = 1'b1;
         tick();
         n_cmp++;
         if (cfg_ready !== (k >= 10)) begin n_err++; $display("FAIL gate_cfg_ready[%0d] got=%b exp=%b", k, cfg_ready, k >= 10); end
         if (m_valid) begin
            n_cmp++;
            if (m_data !== {4{8'h40}}) begin n_err++; $display("FAIL gate_old_data got=%h exp=40404040", m_data); end
            outs++;
         end
      end
      s_valid = 1'b0;
      s_last  = 1'b0;
      tick();
      cfg_valid = 1'b0;
      n_cmp++;
      if (outs !== 8) begin n_err++; $display("FAIL gate_count got=%0d exp=8", outs); end
      one_beat({4{16'h0040}}, 1'b0, q, ql, lat);
      n_cmp++;
      if (q !== {4{8'h10}}) begin n_err++; $display("FAIL gate_new_shift got=%h exp=10101010", q); end

      do_reset();
      cfg_bias  = '0;
      cfg_shift = 4'd3;
      cfg_valid = 1'b1;
      s_valid   = 1'b1;
      s_data    = {4{16'h0050}};
      #1;
      n_cmp += 2;
      if (cfg_ready !== 1'b1) begin n_err++; $display("FAIL same_cfg_ready got=%b exp=1", cfg_ready); end
      if (s_ready !== 1'b0) begin n_err++; $display("FAIL same_s_ready_blocked got=%b exp=0", s_ready); end
      tick();
      cfg_valid = 1'b0;
      #1;
      n_cmp++;
      if (s_ready !== 1'b1) begin n_err++; $display("FAIL same_s_ready_next got=%b exp=1", s_ready); end
      tick();
      s_valid = 1'b0;
      lat = 1;
      while (!m_valid && lat < 20) begin
         tick();
         lat++;
      end
      n_cmp += 2;
      if (lat !== 3) begin n_err++; $display("FAIL same_latency got=%0d exp=3", lat); end
      if (m_data !== {4{8'h0A}}) begin n_err++; $display("FAIL same_data got=%h exp=0a0a0a0a", m_data); end
   endtask

   task automatic test_err_reset();
      logic [R-1:0][WO-1:0] q;
      logic ql;
      int lat;
      do_reset();
      do_cfg(ramp_bias(), 4'd0, 1'b0);
      for (int k = 0; k < 3; k++) one_beat({4{16'h0001}}, 1'b0, q, ql, lat);
      one_beat({4{16'h0001}}, 1'b1, q, ql, lat);
      n_cmp += 3;
      if (q !== {4{8'd31}}) begin n_err++; $display("FAIL err_beat3 got=%h exp=1f1f1f1f", q); end
      if (ql !== 1'b1) begin n_err++; $display("FAIL err_beat3_last got=%b exp=1", ql); end
      if (err_last !== 1'b1) begin n_err++; $display("FAIL err_set got=%b exp=1", err_last); end
      one_beat({4{16'h0001}}, 1'b0, q, ql, lat);
      n_cmp += 2;
      if (q !== {4{8'd1}}) begin n_err++; $display("FAIL err_col0 got=%h exp=01010101", q); end
      if (err_last !== 1'b1) begin n_err++; $display("FAIL err_sticky got=%b exp=1", err_last); end

      s_valid = 1'b1;
      s_data  = {4{16'h0001}};
      tick();
      tick();
      s_valid = 1'b0;
      rstn    = 1'b0;
      tick();
      n_cmp += 3;
      if (m_valid !== 1'b0) begin n_err++; $display("FAIL midrst_m_valid got=%b exp=0", m_valid); end
      if (err_last !== 1'b0) begin n_err++; $display("FAIL midrst_err got=%b exp=0", err_last); end
      if (m_data !== '0) begin n_err++; $display("FAIL midrst_m_data got=%h exp=0", m_data); end
      rstn = 1'b1;
      do_cfg(ramp_bias(), 4'd0, 1'b0);
      one_beat({4{16'h0001}}, 1'b0, q, ql, lat);
      n_cmp++;
      if (q !== {4{8'd1}}) begin n_err++; $display("FAIL midrst_col0 got=%h exp=01010101", q); end
      one_beat({4{16'h0001}}, 1'b0, q, ql, lat);
      n_cmp++;
      if (q !== {4{8'd11}}) begin n_err++; $display("FAIL midrst_col1 got=%h exp=0b0b0b0b", q); end
   endtask

   initial begin
      rstn      = 1'b0;
      s_valid   = 1'b0;
      s_last    = 1'b0;
      s_data    = '0;
      cfg_valid = 1'b0;
      cfg_bias  = '0;
      cfg_shift = '0;
      cfg_relu  = 1'b0;
      m_ready   = 1'b1;
      test_reset();
      test_basic();
      test_sat_relu_round();
      test_col_bias();
      test_back_to_back();
      test_cfg_gating();
      test_err_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
